rr_drain_arbiter: RTL and testbench

- Concrete round-robin drain stage for the arbitrated FIFO bank; replaces the abstract arbiter constraints.
- Observes per-FIFO empty flags and drives the bank's req/gnt_sel pop interface.
- Captures the muxed head word returned in the same cycle into a 2-entry output skid buffer.
- Presents each word with its source tag on a valid/ready port to the downstream consumer.

---
 rtl/rr_drain_arbiter.sv | 99 +++++++++
 tb/tb_rr_drain_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_drain_arbiter.sv
// Round-robin drain stage: pops non-empty FIFOs of a bank in rotating order and
// queues each popped word with its source index in a 2-entry output skid buffer.
module rr_drain_arbiter #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 req,
    output logic [TAGWIDTH-1:0]  gnt_sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAGWIDTH-1:0]  out_tag,
    input  logic                 out_ready
);

    logic [TAGWIDTH-1:0] ptr;
    logic [TAGWIDTH-1:0] cand;
    logic                found;
    logic                any;
    logic [1:0]          cnt;
    logic                wr_idx;
    logic                rd_idx;
    logic                push;
    logic                pop;
    int                  scan_idx;

    logic [WIDTH-1:0]    buf_data [2];
    logic [TAGWIDTH-1:0] buf_tag  [2];

    assign any = |(~empty);

    // Scan starts just past the last grant and visits ptr itself last.
    always_comb begin
        cand     = ptr;
        found    = 1'b0;
        scan_idx = 0;
        for (int off = 1; off <= NUM_FIFOS; off++) begin
            scan_idx = (int'(ptr) + off) % NUM_FIFOS;
            if (!found && !empty[TAGWIDTH'(scan_idx)]) begin
                cand  = TAGWIDTH'(scan_idx);
                found = 1'b1;
            end
        end
    end

    assign gnt_sel   = (any && rst) ? cand : ptr;
    assign req       = any && (cnt != 2'd2) && rst;
    assign push      = req;
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? buf_data[rd_idx] : '0;
    assign out_tag   = out_valid ? buf_tag[rd_idx]  : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= TAGWIDTH'(NUM_FIFOS - 1);
            cnt    <= 2'd0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
        end else begin
            if (push) begin
                ptr    <= gnt_sel;
                wr_idx <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_tag[i]  <= '0;
            end
        end else if (push) begin
            buf_data[wr_idx] <= data_in;
            buf_tag[wr_idx]  <= gnt_sel;
        end
    end

`ifdef FORMAL
    a_req_nonempty: assert property (@(posedge clk) disable iff (!rst)
        req |-> !empty[gnt_sel]);
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
        cnt <= 2'd2);
    a_head_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> $stable(out_data));
    a_push_tag: assert property (@(posedge clk) disable iff (!rst)
        push |=> (buf_tag[$past(wr_idx)] == $past(gnt_sel)));
`endif

endmodule

// File: tb/tb_rr_drain_arbiter.sv
// Self-checking bench for rr_drain_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based round-robin reference model.
module tb_rr_drain_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] empty;
    logic [7:0] data_in;
    logic       req;
    logic [1:0] gnt_sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_tag;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    int m_ptr;
    int m_tag_q[$];
    int m_data_q[$];

    bit       exp_req;
    int       exp_gnt;
    bit       exp_valid;
    int       exp_tag;
    int       exp_data;

    rr_drain_arbiter #(.NUM_FIFOS(N), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .data_in   (data_in),
        .req       (req),
        .gnt_sel   (gnt_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ptr = N - 1;
        m_tag_q.delete();
        m_data_q.delete();
    endfunction

    // Compute this cycle's expected outputs, then drive data_in for the grant.
    task automatic prep(input bit rnd_data);
        int cand;
        cand = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (cand < 0 && empty[i] == 1'b0) cand = i;
        end
        if (!rst) begin
            exp_req = 1'b0;
            exp_gnt = m_ptr;
        end else begin
            exp_gnt = (cand >= 0) ? cand : m_ptr;
            exp_req = (cand >= 0) && (m_tag_q.size() < 2);
        end
        exp_valid = (m_tag_q.size() != 0);
        exp_tag   = exp_valid ? m_tag_q[0]  : 0;
        exp_data  = exp_valid ? m_data_q[0] : 0;
        data_in   = rnd_data ? 8'($urandom) : 8'(8'hA0 + exp_gnt);
        #1;
    endtask

    task automatic tick();
        bit do_pop;
        bit do_push;
        int g;
        int d;
        do_pop  = (m_tag_q.size() != 0) && out_ready;
        do_push = exp_req;
        g       = exp_gnt;
        d       = int'(data_in);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (do_pop) begin
                void'(m_tag_q.pop_front());
                void'(m_data_q.pop_front());
            end
            if (do_push) begin
                m_tag_q.push_back(g);
                m_data_q.push_back(d);
                m_ptr = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        empty     = 4'hF;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        empty     = 4'b0000;
        out_ready = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            prep(1'b0);
            checks++;
            if (req !== 1'b0 || out_valid !== 1'b0 || gnt_sel !== 2'd3) begin
                $display("FAIL reset_hold cyc=%0d got req=%0b vld=%0b gnt=%0d exp req=0 vld=0 gnt=3",
                         c, req, out_valid, gnt_sel);
                errors++;
            end
            tick();
        end
        rst = 1'b1;
        prep(1'b0);
        checks++;
        if (req !== 1'b1 || gnt_sel !== 2'd0) begin
            $display("FAIL reset_release got req=%0b gnt=%0d exp req=1 gnt=0", req, gnt_sel);
            errors++;
        end
    endtask

    // Continues directly from the first post-reset cycle prepared by test_reset.
    task automatic test_round_robin();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) prep(1'b0);
            checks++;
            if (req !== 1'b1 || gnt_sel !== 2'(c % N)) begin
                $display("FAIL rr_gnt cyc=%0d got req=%0b gnt=%0d exp req=1 gnt=%0d",
                         c, req, gnt_sel, c % N);
                errors++;
            end
            checks++;
            if (c == 0) begin
                if (out_valid !== 1'b0) begin
                    $display("FAIL rr_first_valid got %0b exp 0", out_valid);
                    errors++;
                end
            end else if (out_valid !== 1'b1 || out_tag !== 2'(c - 1) || out_data !== 8'(8'hA0 + c - 1)) begin
                $display("FAIL rr_out cyc=%0d got vld=%0b tag=%0d data=%h exp vld=1 tag=%0d data=%h",
                         c, out_valid, out_tag, out_data, c - 1, 8'(8'hA0 + c - 1));
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_sparse();
        empty     = 4'b1011;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            prep(1'b0);
            checks++;
            if (req !== 1'b1 || gnt_sel !== 2'd2) begin
                $display("FAIL sparse_gnt cyc=%0d got req=%0b gnt=%0d exp req=1 gnt=2", c, req, gnt_sel);
                errors++;
            end
            tick();
        end
        empty = 4'b0111;
        prep(1'b0);
        checks++;
        if (req !== 1'b1 || gnt_sel !== 2'd3) begin
            $display("FAIL sparse_switch got req=%0b gnt=%0d exp req=1 gnt=3", req, gnt_sel);
            errors++;
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        empty = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            out_ready = (c == 4);
            prep(1'b0);
            checks++;
            if (c < 2) begin
                if (req !== 1'b1 || gnt_sel !== 2'(c)) begin
                    $display("FAIL bp_grant cyc=%0d got req=%0b gnt=%0d exp req=1 gnt=%0d", c, req, gnt_sel, c);
                    errors++;
                end
            end else if (req !== 1'b0) begin
                $display("FAIL bp_full_req cyc=%0d got %0b exp 0", c, req);
                errors++;
            end
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_data !== 8'hA0) begin
                    $display("FAIL bp_head cyc=%0d got vld=%0b tag=%0d data=%h exp vld=1 tag=0 data=a0",
                             c, out_valid, out_tag, out_data);
                    errors++;
                end
            end
            tick();
        end
        out_ready = 1'b0;
        prep(1'b0);
        checks++;
        if (req !== 1'b1 || gnt_sel !== 2'd2 || out_tag !== 2'd1 || out_data !== 8'hA1) begin
            $display("FAIL bp_resume got req=%0b gnt=%0d tag=%0d data=%h exp req=1 gnt=2 tag=1 data=a1",
                     req, gnt_sel, out_tag, out_data);
            errors++;
        end
        tick();
    endtask

    task automatic test_all_empty();
        do_reset();
        empty = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            prep(1'b0);
            tick();
        end
        empty     = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            prep(1'b0);
            checks++;
            if (req !== 1'b0 || gnt_sel !== 2'd1) begin
                $display("FAIL empty_hold cyc=%0d got req=%0b gnt=%0d exp req=0 gnt=1", c, req, gnt_sel);
                errors++;
            end
            checks++;
            if (c < 2) begin
                if (out_valid !== 1'b1 || out_tag !== 2'(c) || out_data !== 8'(8'hA0 + c)) begin
                    $display("FAIL empty_drain cyc=%0d got vld=%0b tag=%0d data=%h exp vld=1 tag=%0d data=%h",
                             c, out_valid, out_tag, out_data, c, 8'(8'hA0 + c));
                    errors++;
                end
            end else if (out_valid !== 1'b0 || out_tag !== 2'd0 || out_data !== 8'h00) begin
                $display("FAIL empty_idle cyc=%0d got vld=%0b tag=%0d data=%h exp vld=0 tag=0 data=00",
                         c, out_valid, out_tag, out_data);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        empty = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            prep(1'b0);
            tick();
        end
        prep(1'b0);
        checks++;
        if (out_valid !== 1'b1 || req !== 1'b0) begin
            $display("FAIL mid_full got vld=%0b req=%0b exp vld=1 req=0", out_valid, req);
            errors++;
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || req !== 1'b0 || out_data !== 8'h00) begin
            $display("FAIL mid_async got vld=%0b req=%0b data=%h exp vld=0 req=0 data=00",
                     out_valid, req, out_data);
            errors++;
        end
        prep(1'b0);
        tick();
        empty = 4'b1001;
        rst   = 1'b1;
        prep(1'b0);
        checks++;
        if (req !== 1'b1 || gnt_sel !== 2'd1) begin
            $display("FAIL mid_release got req=%0b gnt=%0d exp req=1 gnt=1", req, gnt_sel);
            errors++;
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            empty     = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            prep(1'b1);
            checks++;
            if (req !== exp_req || (exp_req && gnt_sel !== 2'(exp_gnt))) begin
                $display("FAIL rnd_grant cyc=%0d got req=%0b gnt=%0d exp req=%0b gnt=%0d",
                         c, req, gnt_sel, exp_req, exp_gnt);
                errors++;
            end
            checks++;
            if (out_valid !== exp_valid || out_tag !== 2'(exp_tag) || out_data !== 8'(exp_data)) begin
                $display("FAIL rnd_out cyc=%0d got vld=%0b tag=%0d data=%h exp vld=%0b tag=%0d data=%h",
                         c, out_valid, out_tag, out_data, exp_valid, exp_tag, 8'(exp_data));
                errors++;
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b0;
        empty     = 4'hF;
        data_in   = 8'h00;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_all_empty();
        test_midrun_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
